// File: rtl/cpu_pkg.sv
// Shared constants for the CPU datapath: register indices, opcodes, flag
// positions, control-vector bit positions and halt FSM states.
package cpu_pkg;

    localparam int NUM_GP = 8;
    localparam int REG_A  = 0;
    localparam int REG_B  = 1;
    localparam int REG_C  = 2;
    localparam int REG_D  = 3;
    localparam int REG_E  = 4;
    localparam int REG_F  = 5;
    localparam int REG_H  = 6;
    localparam int REG_G  = 7;

    localparam logic [7:0] OP_NOP  = 8'h00, OP_LDA  = 8'h01, OP_LDB  = 8'h02, OP_LDC  = 8'h03;
    localparam logic [7:0] OP_STA  = 8'h04, OP_STB  = 8'h05, OP_STC  = 8'h06, OP_MOVAB = 8'h07;
    localparam logic [7:0] OP_MOVAC = 8'h08, OP_MOVBA = 8'h09, OP_MOVBC = 8'h0A, OP_MOVCA = 8'h0B;
    localparam logic [7:0] OP_MOVCB = 8'h0C, OP_ADD = 8'h0D, OP_SUB  = 8'h0E, OP_AND  = 8'h0F;
    localparam logic [7:0] OP_OR   = 8'h10, OP_XOR  = 8'h11, OP_NOT  = 8'h12, OP_MOVCI = 8'h13;
    localparam logic [7:0] OP_INC  = 8'h14, OP_DEC  = 8'h15, OP_SHL  = 8'h16, OP_SHR  = 8'h17;
    localparam logic [7:0] OP_CMP  = 8'h18, OP_JMP  = 8'h19, OP_JZ   = 8'h1A, OP_JN   = 8'h1B;
    localparam logic [7:0] OP_HLT  = 8'h1C;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int PC_RESET = 3;
    localparam int PC_IN    = 2;
    localparam int PC_INC   = 1;
    localparam int PC_OUT   = 0;

    localparam int MAR_IN  = 5;
    localparam int MDR_IN  = 4;
    localparam int CIR_IN  = 3;
    localparam int CIR_OUT = 2;
    localparam int RAM_IN  = 1;
    localparam int RAM_OUT = 0;

    localparam int AR_IN  = 1;
    localparam int AR_OUT = 0;

    localparam int SC_RESET = 1;
    localparam int SC_INC   = 0;

    // Bus source slots: PC, CIR low byte, AR, RAM, then GP registers 0..7.
    localparam int NUM_SRC  = 12;
    localparam int SRC_PC   = 0;
    localparam int SRC_CIR  = 1;
    localparam int SRC_AR   = 2;
    localparam int SRC_RAM  = 3;
    localparam int SRC_REG0 = 4;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } halt_state_e;

endpackage

// File: rtl/cpu_bus_mux.sv
// OR-combining internal bus driver with multi-driver contention detect.
module cpu_bus_mux #(
    parameter int DW = 8,
    parameter int N  = 12
) (
    input  logic [N-1:0][DW-1:0] src,
    input  logic [N-1:0]         en,
    output logic [DW-1:0]        bus,
    output logic                 contention
);

    always_comb begin
        bus = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (en[i]) bus = bus | src[i];
        end
    end

    assign contention = ($countones(en) > 1);

endmodule

// File: rtl/cpu_datapath.sv
// CPU datapath: executes control-unit strobes over a single internal bus and
// holds PC, MAR, MDR, CIR, AR, GP registers, flags, step counter and halt latch.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_run,
    input  logic [3:0]    pc_ctl,
    input  logic [5:0]    mem_ctl,
    input  logic [1:0]    ar_ctl,
    input  logic [1:0]    sc_ctl,
    input  logic [7:0]    reg_in,
    input  logic [7:0]    reg_out,
    input  logic [7:0]    reg_rst,
    input  logic          regC_sel,
    input  logic          flag_in,
    input  logic          halt_req,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_flags,
    input  logic [15:0]   rom_rdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] rom_addr,
    output logic [DW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic [DW-1:0] regA_q,
    output logic [DW-1:0] regB_q,
    output logic [DW-1:0] regC_q,
    output logic [SW-1:0] step,
    output logic [7:0]    opcode,
    output logic [DW-1:0] operand,
    output logic [3:0]    flags,
    output logic [DW-1:0] bus,
    output logic          halted,
    output logic          bus_err
);

    logic [DW-1:0] pc_q, mar_q, ar_q;
    logic [15:0]   mdr_q, cir_q;
    logic [DW-1:0] gp_q [NUM_GP];
    logic [3:0]    flags_q;
    logic [SW-1:0] step_q;
    logic          bus_err_q;
    halt_state_e   state_q, state_d;

    logic [NUM_SRC-1:0][DW-1:0] src;
    logic [NUM_SRC-1:0]         src_en;
    logic                       contention;

    always_comb begin
        src          = '0;
        src[SRC_PC]  = pc_q;
        src[SRC_CIR] = cir_q[DW-1:0];
        src[SRC_AR]  = ar_q;
        src[SRC_RAM] = ram_rdata;
        for (int unsigned i = 0; i < NUM_GP; i++) begin
            src[SRC_REG0 + i] = gp_q[i];
        end
    end

    assign src_en = {reg_out, mem_ctl[RAM_OUT], ar_ctl[AR_OUT], mem_ctl[CIR_OUT], pc_ctl[PC_OUT]};

    cpu_bus_mux #(
        .DW (DW),
        .N  (NUM_SRC)
    ) u_bus_mux (
        .src        (src),
        .en         (src_en),
        .bus        (bus),
        .contention (contention)
    );

    assign halted = (state_q == ST_HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (halt_req && cpu_run) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            mar_q     <= '0;
            ar_q      <= '0;
            mdr_q     <= '0;
            cir_q     <= '0;
            flags_q   <= '0;
            step_q    <= '0;
            bus_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
        end else begin
            bus_err_q <= bus_err_q | contention;
            if (!halted) begin
                if (pc_ctl[PC_RESET])    pc_q <= '0;
                else if (pc_ctl[PC_IN])  pc_q <= bus;
                else if (pc_ctl[PC_INC]) pc_q <= pc_q + DW'(1);

                if (mem_ctl[MAR_IN]) mar_q <= bus;
                if (mem_ctl[MDR_IN]) mdr_q <= rom_rdata;
                if (mem_ctl[CIR_IN]) cir_q <= mdr_q;
                if (ar_ctl[AR_IN])   ar_q  <= bus;
                if (flag_in)         flags_q <= alu_flags;

                for (int unsigned i = 0; i < NUM_GP; i++) begin
                    if (reg_rst[i])     gp_q[i] <= '0;
                    else if (reg_in[i]) gp_q[i] <= (i == REG_C && !regC_sel) ? alu_result : bus;
                end

                if (cpu_run) begin
                    if (sc_ctl[SC_RESET])    step_q <= '0;
                    else if (sc_ctl[SC_INC]) step_q <= step_q + SW'(1);
                end
            end
        end
    end

    assign rom_addr  = mar_q;
    assign ram_addr  = ar_q;
    assign ram_wdata = bus;
    assign ram_we    = mem_ctl[RAM_IN] & ~halted;
    assign regA_q    = gp_q[REG_A];
    assign regB_q    = gp_q[REG_B];
    assign regC_q    = gp_q[REG_C];
    assign step      = step_q;
    assign opcode    = cir_q[15:8];
    assign operand   = ar_q;
    assign flags     = flags_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized
// strobes checked against a behavioural model of the datapath.
module tb_cpu_datapath;

    logic        clk, rst, cpu_run;
    logic [3:0]  pc_ctl;
    logic [5:0]  mem_ctl;
    logic [1:0]  ar_ctl, sc_ctl;
    logic [7:0]  reg_in, reg_out, reg_rst;
    logic        regC_sel, flag_in, halt_req;
    logic [7:0]  alu_result;
    logic [3:0]  alu_flags;
    logic [15:0] rom_rdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  rom_addr, ram_addr, ram_wdata;
    logic        ram_we;
    logic [7:0]  regA_q, regB_q, regC_q;
    logic [3:0]  step;
    logic [7:0]  opcode, operand;
    logic [3:0]  flags;
    logic [7:0]  bus;
    logic        halted, bus_err;

    logic [15:0] rom [256];
    assign rom_rdata = rom[rom_addr];

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [7:0]  m_pc, m_mar, m_ar;
    logic [15:0] m_mdr, m_cir;
    logic [7:0]  m_gp [8];
    logic [3:0]  m_flags, m_step;
    logic        m_halted, m_bus_err;

    cpu_datapath #(.DW(8), .SW(4)) dut (
        .clk(clk), .rst(rst), .cpu_run(cpu_run), .pc_ctl(pc_ctl), .mem_ctl(mem_ctl),
        .ar_ctl(ar_ctl), .sc_ctl(sc_ctl), .reg_in(reg_in), .reg_out(reg_out),
        .reg_rst(reg_rst), .regC_sel(regC_sel), .flag_in(flag_in), .halt_req(halt_req),
        .alu_result(alu_result), .alu_flags(alu_flags), .rom_rdata(rom_rdata),
        .ram_rdata(ram_rdata), .rom_addr(rom_addr), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .regA_q(regA_q), .regB_q(regB_q),
        .regC_q(regC_q), .step(step), .opcode(opcode), .operand(operand),
        .flags(flags), .bus(bus), .halted(halted), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic m_reset();
        m_pc = 0; m_mar = 0; m_ar = 0; m_mdr = 0; m_cir = 0;
        m_flags = 0; m_step = 0; m_halted = 0; m_bus_err = 0;
        for (int i = 0; i < 8; i++) m_gp[i] = 0;
    endtask

    function automatic logic [7:0] model_bus();
        logic [7:0] b;
        b = 8'h00;
        if (pc_ctl[0])  b = b | m_pc;
        if (mem_ctl[2]) b = b | m_cir[7:0];
        if (ar_ctl[0])  b = b | m_ar;
        if (mem_ctl[0]) b = b | ram_rdata;
        for (int i = 0; i < 8; i++) if (reg_out[i]) b = b | m_gp[i];
        return b;
    endfunction

    function automatic int model_drivers();
        int n;
        n = int'(pc_ctl[0]) + int'(mem_ctl[2]) + int'(ar_ctl[0]) + int'(mem_ctl[0]);
        for (int i = 0; i < 8; i++) n += int'(reg_out[i]);
        return n;
    endfunction

    task automatic model_clock();
        logic [7:0] b;
        b = model_bus();
        if (model_drivers() > 1) m_bus_err = 1'b1;
        if (!m_halted) begin
            if (pc_ctl[3])      m_pc = 8'h00;
            else if (pc_ctl[2]) m_pc = b;
            else if (pc_ctl[1]) m_pc = m_pc + 8'd1;
            if (mem_ctl[3]) m_cir = m_mdr;
            if (mem_ctl[4]) m_mdr = rom[m_mar];
            if (mem_ctl[5]) m_mar = b;
            if (ar_ctl[1])  m_ar = b;
            for (int i = 0; i < 8; i++) begin
                if (reg_rst[i])     m_gp[i] = 8'h00;
                else if (reg_in[i]) m_gp[i] = (i == 2 && !regC_sel) ? alu_result : b;
            end
            if (flag_in) m_flags = alu_flags;
            if (cpu_run) begin
                if (sc_ctl[1])      m_step = 4'd0;
                else if (sc_ctl[0]) m_step = m_step + 4'd1;
            end
            if (cpu_run && halt_req) m_halted = 1'b1;
        end
    endtask

    task automatic idle();
        pc_ctl = 0; mem_ctl = 0; ar_ctl = 0; sc_ctl = 0;
        reg_in = 0; reg_out = 0; reg_rst = 0; regC_sel = 0;
        flag_in = 0; halt_req = 0; alu_result = 0; alu_flags = 0; ram_rdata = 0;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h1342;
        rst = 1'b1; cpu_run = 1'b1;
        idle();
        m_reset();
        @(posedge clk); #1;
        tests++; if (rom_addr !== 8'h00) begin fails++; $display("FAIL reset_mar got %h want 00", rom_addr); end
        tests++; if (step !== 4'h0) begin fails++; $display("FAIL reset_step got %h want 0", step); end
        tests++; if ({halted, bus_err} !== 2'b00) begin fails++; $display("FAIL reset_halt_err got %b want 00", {halted, bus_err}); end
        tests++; if (bus !== 8'h00) begin fails++; $display("FAIL reset_bus_idle got %h want 00", bus); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        idle(); pc_ctl[0] = 1; mem_ctl[5] = 1; sc_ctl[0] = 1; tick();
        idle(); mem_ctl[4] = 1; pc_ctl[1] = 1; sc_ctl[0] = 1; tick();
        idle(); mem_ctl[3] = 1; sc_ctl[0] = 1; tick();
        idle(); mem_ctl[2] = 1; ar_ctl[1] = 1; sc_ctl[0] = 1; tick();
        idle(); sc_ctl[0] = 1; tick();
        idle();
        tests++; if (rom_addr !== 8'h00) begin fails++; $display("FAIL fetch_mar got %h want 00", rom_addr); end
        tests++; if (opcode !== 8'h13) begin fails++; $display("FAIL fetch_opcode got %h want 13", opcode); end
        tests++; if (operand !== 8'h42) begin fails++; $display("FAIL fetch_operand got %h want 42", operand); end
        tests++; if (step !== 4'd5) begin fails++; $display("FAIL fetch_step got %0d want 5", step); end
        pc_ctl[0] = 1; #1;
        tests++; if (bus !== 8'h01) begin fails++; $display("FAIL fetch_pc got %h want 01", bus); end
        mem_ctl[2] = 1; pc_ctl[0] = 0; #1;
        tests++; if (bus !== 8'h42) begin fails++; $display("FAIL fetch_cir_low got %h want 42", bus); end
        idle();
    endtask

    task automatic test_mov_imm();
        idle(); flag_in = 1; alu_flags = 4'b1101; tick();
        tests++; if (flags !== 4'b1101) begin fails++; $display("FAIL flag_capture got %b want 1101", flags); end
        idle(); ar_ctl[0] = 1; reg_in[2] = 1; regC_sel = 1; flag_in = 1; alu_flags = 4'b0000; alu_result = 8'h99; tick();
        idle();
        tests++; if (regC_q !== 8'h42) begin fails++; $display("FAIL mov_c_imm got %h want 42", regC_q); end
        tests++; if (flags !== 4'b0000) begin fails++; $display("FAIL mov_flags got %b want 0000", flags); end
    endtask

    task automatic test_alu_writeback();
        idle(); alu_result = 8'h80; reg_in[2] = 1; regC_sel = 0; ram_rdata = 8'h11; mem_ctl[0] = 1; tick();
        tests++; if (regC_q !== 8'h80) begin fails++; $display("FAIL alu_wb_c got %h want 80", regC_q); end
        idle(); reg_out[2] = 1; reg_in[6] = 1; tick();
        idle(); reg_out[6] = 1; #1;
        tests++; if (bus !== 8'h80) begin fails++; $display("FAIL move_h got %h want 80", bus); end
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL no_contention got %b want 0", bus_err); end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int drv;
            logic [7:0] exp_bus;
            drv = int'($urandom_range(0, 12));
            cpu_run    = ($urandom_range(0, 7) != 0);
            pc_ctl     = {($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), (drv == 0)};
            mem_ctl    = {1'($urandom), 1'($urandom), 1'($urandom), (drv == 1), 1'($urandom), (drv == 3)};
            ar_ctl     = {1'($urandom), (drv == 2)};
            sc_ctl     = {($urandom_range(0, 7) == 0), 1'($urandom)};
            reg_out    = (drv >= 4 && drv < 12) ? 8'(1 << (drv - 4)) : 8'h00;
            reg_in     = 8'($urandom);
            reg_rst    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            regC_sel   = 1'($urandom);
            flag_in    = 1'($urandom);
            alu_result = 8'($urandom);
            alu_flags  = 4'($urandom);
            ram_rdata  = 8'($urandom);
            halt_req   = 1'b0;
            #1;
            exp_bus = model_bus();
            tests++; if (bus !== exp_bus) begin fails++; $display("FAIL rnd_bus cyc %0d got %h want %h", n, bus, exp_bus); end
            tests++; if (ram_we !== mem_ctl[1]) begin fails++; $display("FAIL rnd_we cyc %0d got %b want %b", n, ram_we, mem_ctl[1]); end
            tick();
            tests++; if (rom_addr !== m_mar) begin fails++; $display("FAIL rnd_mar cyc %0d got %h want %h", n, rom_addr, m_mar); end
            tests++; if (ram_addr !== m_ar) begin fails++; $display("FAIL rnd_ar cyc %0d got %h want %h", n, ram_addr, m_ar); end
            tests++; if ({regA_q, regB_q, regC_q} !== {m_gp[0], m_gp[1], m_gp[2]}) begin fails++;
                $display("FAIL rnd_abc cyc %0d got %h%h%h want %h%h%h", n, regA_q, regB_q, regC_q, m_gp[0], m_gp[1], m_gp[2]); end
            tests++; if (step !== m_step) begin fails++; $display("FAIL rnd_step cyc %0d got %h want %h", n, step, m_step); end
            tests++; if (opcode !== m_cir[15:8]) begin fails++; $display("FAIL rnd_opcode cyc %0d got %h want %h", n, opcode, m_cir[15:8]); end
            tests++; if (flags !== m_flags) begin fails++; $display("FAIL rnd_flags cyc %0d got %b want %b", n, flags, m_flags); end
            tests++; if ({halted, bus_err} !== {m_halted, m_bus_err}) begin fails++;
                $display("FAIL rnd_status cyc %0d got %b want %b", n, {halted, bus_err}, {m_halted, m_bus_err}); end
        end
        cpu_run = 1'b1;
        idle();
    endtask

    task automatic test_contention();
        idle(); ram_rdata = 8'h0F; mem_ctl[0] = 1; pc_ctl[2] = 1; tick();
        idle(); ram_rdata = 8'hF0; mem_ctl[0] = 1; ar_ctl[1] = 1; tick();
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL pre_contention got %b want 0", bus_err); end
        idle(); pc_ctl[0] = 1; ar_ctl[0] = 1; mem_ctl[5] = 1; #1;
        tests++; if (bus !== 8'hFF) begin fails++; $display("FAIL contention_bus got %h want ff", bus); end
        tick();
        idle();
        tests++; if (rom_addr !== 8'hFF) begin fails++; $display("FAIL contention_mar got %h want ff", rom_addr); end
        tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL contention_err got %b want 1", bus_err); end
        tick(); tick();
        tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL contention_sticky got %b want 1", bus_err); end
    endtask

    task automatic test_wrap_priority();
        idle(); ram_rdata = 8'hFF; mem_ctl[0] = 1; pc_ctl[2] = 1; tick();
        idle(); pc_ctl[1] = 1; tick();
        idle(); pc_ctl[0] = 1; #1;
        tests++; if (bus !== 8'h00) begin fails++; $display("FAIL pc_wrap got %h want 00", bus); end
        idle(); sc_ctl[1] = 1; tick();
        for (int i = 0; i < 15; i++) begin idle(); sc_ctl[0] = 1; tick(); end
        tests++; if (step !== 4'd15) begin fails++; $display("FAIL step_15 got %0d want 15", step); end
        idle(); sc_ctl[0] = 1; tick();
        tests++; if (step !== 4'd0) begin fails++; $display("FAIL step_wrap got %0d want 0", step); end
        idle(); sc_ctl[0] = 1; tick(); tick();
        idle(); sc_ctl = 2'b11; tick();
        tests++; if (step !== 4'd0) begin fails++; $display("FAIL sc_reset_prio got %0d want 0", step); end
        idle(); sc_ctl[0] = 1; cpu_run = 1'b0; tick();
        tests++; if (step !== 4'd0) begin fails++; $display("FAIL run_freeze got %0d want 0", step); end
        cpu_run = 1'b1;
        idle(); ram_rdata = 8'h55; mem_ctl[0] = 1; pc_ctl = 4'b1100; tick();
        idle(); pc_ctl[0] = 1; #1;
        tests++; if (bus !== 8'h00) begin fails++; $display("FAIL pc_reset_prio got %h want 00", bus); end
        idle(); ram_rdata = 8'h20; mem_ctl[0] = 1; pc_ctl = 4'b0110; tick();
        idle(); pc_ctl[0] = 1; #1;
        tests++; if (bus !== 8'h20) begin fails++; $display("FAIL pc_in_prio got %h want 20", bus); end
        idle();
    endtask

    task automatic test_halt();
        idle(); sc_ctl[1] = 1; tick();
        for (int i = 0; i < 5; i++) begin idle(); sc_ctl[0] = 1; tick(); end
        idle(); halt_req = 1; pc_ctl[1] = 1; tick();
        idle();
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_enter got %b want 1", halted); end
        tests++; if (step !== 4'd5) begin fails++; $display("FAIL halt_step got %0d want 5", step); end
        sc_ctl[0] = 1; pc_ctl = 4'b0011; mem_ctl[1] = 1; reg_in[0] = 1; #1;
        tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL halt_we got %b want 0", ram_we); end
        tests++; if (bus !== 8'h21) begin fails++; $display("FAIL halt_same_cycle_pc got %h want 21", bus); end
        tick(); tick();
        tests++; if (step !== 4'd5) begin fails++; $display("FAIL halt_step_hold got %0d want 5", step); end
        tests++; if (bus !== 8'h21) begin fails++; $display("FAIL halt_pc_hold got %h want 21", bus); end
        tests++; if (regA_q !== 8'h00 && regA_q !== m_gp[0]) begin fails++; $display("FAIL halt_reg_hold got %h want %h", regA_q, m_gp[0]); end
        idle();
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        reg_out[6] = 1;
        #1;
        tests++; if (bus !== 8'h00) begin fails++; $display("FAIL arst_reg_h got %h want 00", bus); end
        tests++; if ({rom_addr, ram_addr} !== 16'h0000) begin fails++; $display("FAIL arst_mar_ar got %h%h want 0000", rom_addr, ram_addr); end
        tests++; if ({regA_q, regB_q, regC_q, opcode} !== 32'h0) begin fails++;
            $display("FAIL arst_regs got %h%h%h%h want 0", regA_q, regB_q, regC_q, opcode); end
        tests++; if ({step, flags, halted, bus_err} !== 10'h0) begin fails++;
            $display("FAIL arst_status got %h want 000", {step, flags, halted, bus_err}); end
        rst = 1'b0;
        m_reset();
        idle(); sc_ctl[0] = 1; tick();
        idle();
        tests++; if ({step, halted} !== {4'd1, 1'b0}) begin fails++; $display("FAIL arst_release got %h want 2", {step, halted}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_mov_imm();
        test_alu_writeback();
        test_random();
        test_contention();
        test_wrap_priority();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
